brg_xcel_master_arbiter: RTL and testbench

BRG_XCEL_MASTER_ARBITER -- requirements
Module: brg_xcel_master_arbiter

---
 rtl/brg_xcel_pkg.sv | 17 +
 rtl/brg_xcel_master_arbiter_if.sv | 59 +++++
 rtl/brg_rr_arb2.sv | 59 +++++
 rtl/brg_xcel_master_arbiter.sv | 108 ++++++++++
 tb/tb_brg_xcel_master_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/brg_xcel_pkg.sv
// Shared definitions for the accelerator master arbiter: op encoding,
// requester index type and the arbiter lock states.
package brg_xcel_pkg;

  localparam int unsigned REQ_IDX_W = 1;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/brg_xcel_master_arbiter_if.sv
// Bundle of requester, endpoint and response signals around the master arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's.
interface brg_xcel_master_arbiter_if #(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 32,
  parameter int unsigned load_id_width_p = 11,
  parameter int unsigned max_out_loads_p = 16
);
  localparam int unsigned MASK_W = data_width_p / 8;
  localparam int unsigned OPQ_W  = load_id_width_p - 1;
  localparam int unsigned CNT_W  = $clog2(max_out_loads_p + 1);

  logic [1:0]                   req_v_i;
  logic [1:0]                   req_type_i;
  logic [1:0][addr_width_p-1:0] req_addr_i;
  logic [1:0][data_width_p-1:0] req_data_i;
  logic [1:0][MASK_W-1:0]       req_mask_i;
  logic [1:0][OPQ_W-1:0]        req_opq_i;
  logic [1:0]                   req_ready_o;

  logic                         out_v_o;
  logic                         out_type_o;
  logic [addr_width_p-1:0]      out_addr_o;
  logic [data_width_p-1:0]      out_data_o;
  logic [MASK_W-1:0]            out_mask_o;
  logic [load_id_width_p-1:0]   out_opq_o;
  logic                         out_ready_i;

  logic                         ret_v_i;
  logic [data_width_p-1:0]      ret_data_i;
  logic [load_id_width_p-1:0]   ret_opq_i;
  logic [1:0]                   ret_v_o;
  logic [data_width_p-1:0]      ret_data_o;
  logic [OPQ_W-1:0]             ret_opq_o;

  logic [CNT_W-1:0]             loads_out_o;
  logic                         err_o;

  modport master (
    input  req_v_i, req_type_i, req_addr_i, req_data_i, req_mask_i, req_opq_i,
    output req_ready_o,
    output out_v_o, out_type_o, out_addr_o, out_data_o, out_mask_o, out_opq_o,
    input  out_ready_i,
    input  ret_v_i, ret_data_i, ret_opq_i,
    output ret_v_o, ret_data_o, ret_opq_o,
    output loads_out_o, err_o
  );

  modport slave (
    output req_v_i, req_type_i, req_addr_i, req_data_i, req_mask_i, req_opq_i,
    input  req_ready_o,
    input  out_v_o, out_type_o, out_addr_o, out_data_o, out_mask_o, out_opq_o,
    output out_ready_i,
    output ret_v_i, ret_data_i, ret_opq_i,
    input  ret_v_o, ret_data_o, ret_opq_o,
    input  loads_out_o, err_o
  );

endinterface

// File: rtl/brg_rr_arb2.sv
// Two-input round-robin arbiter with a grant lock that holds an offered
// request until the endpoint accepts it.
module brg_rr_arb2
  import brg_xcel_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] elig_i,
  input  logic       ready_i,
  output req_idx_t   grant_c
);

  arb_state_e state_q, state_d;
  req_idx_t   last_q, last_d;
  req_idx_t   lock_idx_q, lock_idx_d;
  logic       valid_c;
  logic       xfer_c;

  // Locked grant wins; otherwise favour whichever requester was not served last.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_idx_d = lock_idx_q;
    grant_c    = ~last_q;

    if (state_q == ARB_LOCKED) begin
      grant_c = lock_idx_q;
    end else if (elig_i[0] && !elig_i[1]) begin
      grant_c = req_idx_t'(0);
    end else if (elig_i[1] && !elig_i[0]) begin
      grant_c = req_idx_t'(1);
    end

    valid_c = elig_i[grant_c];
    xfer_c  = valid_c && ready_i;

    // A locked load that loses eligibility (counter full) keeps its lock.
    if (xfer_c) begin
      state_d = ARB_OPEN;
      last_d  = grant_c;
    end else if (valid_c) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = grant_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB_OPEN;
      last_q     <= req_idx_t'(1);
      lock_idx_q <= req_idx_t'(0);
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/brg_xcel_master_arbiter.sv
// Arbitrates two accelerator requesters onto one endpoint, caps outstanding
// loads and routes load responses back by the requester bit of the load id.
module brg_xcel_master_arbiter
  import brg_xcel_pkg::*;
#(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 32,
  parameter int unsigned load_id_width_p = 11,
  parameter int unsigned max_out_loads_p = 16
) (
  input logic                 clk_i,
  input logic                 reset_i,
  brg_xcel_master_arbiter_if.master bus
);

  localparam int unsigned MASK_W = data_width_p / 8;
  localparam int unsigned OPQ_W  = load_id_width_p - 1;
  localparam int unsigned CNT_W  = $clog2(max_out_loads_p + 1);

  logic [CNT_W-1:0]        loads_q, loads_d;
  logic                    err_q, err_d;
  logic [1:0]              elig_c;
  req_idx_t                grant_c;
  logic                    out_v_c;
  logic                    load_xfer_c;
  logic [addr_width_p-1:0] out_addr_c;
  logic [data_width_p-1:0] out_data_c;
  logic [MASK_W-1:0]       out_mask_c;
  logic [OPQ_W-1:0]        out_opq_c;
  logic [1:0]              req_ready_c;
  logic [1:0]              ret_v_c;

  // Stores are always eligible; loads only while a slot is free.
  always_comb begin
    elig_c = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig_c[i] = bus.req_v_i[i] &&
                  (bus.req_type_i[i] == OP_STORE || loads_q < CNT_W'(max_out_loads_p));
    end
  end

  brg_rr_arb2 u_rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .elig_i  (elig_c),
    .ready_i (bus.out_ready_i),
    .grant_c (grant_c)
  );

  always_comb begin
    out_v_c     = !reset_i && elig_c[grant_c];
    out_addr_c  = bus.req_addr_i[grant_c];
    out_data_c  = bus.req_data_i[grant_c];
    out_mask_c  = bus.req_mask_i[grant_c];
    out_opq_c   = bus.req_opq_i[grant_c];
    load_xfer_c = out_v_c && bus.out_ready_i && (bus.req_type_i[grant_c] == OP_LOAD);
    req_ready_c = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_ready_c[i] = out_v_c && bus.out_ready_i && (grant_c == req_idx_t'(i));
    end
  end

  // Response steering by the requester bit carried in the load id MSB.
  always_comb begin
    ret_v_c = 2'b00;
    if (!reset_i && bus.ret_v_i) begin
      ret_v_c[bus.ret_opq_i[load_id_width_p-1]] = 1'b1;
    end
  end

  // A return with nothing outstanding is a protocol error and never underflows.
  always_comb begin
    loads_d = loads_q;
    err_d   = err_q;
    if (bus.ret_v_i && loads_q == '0) begin
      err_d = 1'b1;
    end
    if (load_xfer_c && !bus.ret_v_i) begin
      loads_d = loads_q + CNT_W'(1);
    end else if (!load_xfer_c && bus.ret_v_i && loads_q != '0) begin
      loads_d = loads_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      loads_q <= '0;
      err_q   <= 1'b0;
    end else begin
      loads_q <= loads_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready_o = req_ready_c;
  assign bus.out_v_o     = out_v_c;
  assign bus.out_type_o  = bus.req_type_i[grant_c];
  assign bus.out_addr_o  = out_addr_c;
  assign bus.out_data_o  = out_data_c;
  assign bus.out_mask_o  = out_mask_c;
  assign bus.out_opq_o   = {grant_c, out_opq_c};
  assign bus.ret_v_o     = ret_v_c;
  assign bus.ret_data_o  = bus.ret_data_i;
  assign bus.ret_opq_o   = bus.ret_opq_i[OPQ_W-1:0];
  assign bus.loads_out_o = loads_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_brg_xcel_master_arbiter.sv
// Directed bench for brg_xcel_master_arbiter: a vector table for steady-state
// arbitration and routing, then hand sequences for lock, load cap and reset.
module tb_brg_xcel_master_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  brg_xcel_master_arbiter_if #(
    .data_width_p(32), .addr_width_p(32), .load_id_width_p(11), .max_out_loads_p(16)
  ) bus ();

  brg_xcel_master_arbiter #(
    .data_width_p(32), .addr_width_p(32), .load_id_width_p(11), .max_out_loads_p(16)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  ty;
    logic        rdy;
    logic        rv;
    logic [10:0] ropq;
    logic        e_ov;
    logic [10:0] e_opq;
    logic [1:0]  e_rdy;
    logic [4:0]  e_loads;
    logic        e_err;
    logic [1:0]  e_rvo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] ty,
                       input logic rdy, input logic rv, input logic [10:0] ropq);
    rst             = r;
    bus.req_v_i     = v;
    bus.req_type_i  = ty;
    bus.out_ready_i = rdy;
    bus.ret_v_i     = rv;
    bus.ret_opq_i   = ropq;
  endtask

  task automatic reset_dut();
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 11'h000);
    tick();
  endtask

  initial begin
    bus.req_addr_i[0] = 32'h0000_0100;
    bus.req_addr_i[1] = 32'h0000_0200;
    bus.req_data_i[0] = 32'hA5A5_0000;
    bus.req_data_i[1] = 32'h5A5A_1111;
    bus.req_mask_i[0] = 4'h3;
    bus.req_mask_i[1] = 4'hC;
    bus.req_opq_i[0]  = 10'h011;
    bus.req_opq_i[1]  = 10'h022;
    bus.ret_data_i    = 32'hDEAD_BEEF;

    //          rst  v      ty     rdy  rv   ropq     ov   opq      rdy    lds   err  rvo
    vecs[0] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 11'h400, 1'b0, 11'h000, 2'b00, 5'd0, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 11'h000, 1'b1, 11'h011, 2'b01, 5'd0, 1'b0, 2'b00};
    vecs[2] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 11'h000, 1'b1, 11'h422, 2'b10, 5'd1, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 11'h000, 1'b1, 11'h011, 2'b01, 5'd2, 1'b0, 2'b00};
    vecs[4] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 11'h000, 1'b1, 11'h422, 2'b10, 5'd3, 1'b0, 2'b00};
    vecs[5] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 11'h42A, 1'b0, 11'h000, 2'b00, 5'd4, 1'b0, 2'b10};
    vecs[6] = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 11'h011, 1'b1, 11'h011, 2'b01, 5'd3, 1'b0, 2'b01};
    vecs[7] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 11'h000, 1'b1, 11'h422, 2'b10, 5'd3, 1'b0, 2'b00};
    vecs[8] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 11'h000, 1'b1, 11'h011, 2'b01, 5'd3, 1'b0, 2'b00};
    vecs[9] = '{1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 11'h000, 1'b1, 11'h422, 2'b10, 5'd3, 1'b0, 2'b00};

    reset_dut();
    reset_dut();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].ty, vecs[i].rdy, vecs[i].rv, vecs[i].ropq);
      #1;
      chk($sformatf("vec%0d out_v", i), 32'(bus.out_v_o), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d out_opq", i), 32'(bus.out_opq_o), 32'(vecs[i].e_opq));
      chk($sformatf("vec%0d req_ready", i), 32'(bus.req_ready_o), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d loads", i), 32'(bus.loads_out_o), 32'(vecs[i].e_loads));
      chk($sformatf("vec%0d err", i), 32'(bus.err_o), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d ret_v", i), 32'(bus.ret_v_o), 32'(vecs[i].e_rvo));
      if (vecs[i].rv) begin
        chk($sformatf("vec%0d ret_opq", i), 32'(bus.ret_opq_o), 32'(vecs[i].ropq[9:0]));
        chk($sformatf("vec%0d ret_data", i), bus.ret_data_o, 32'hDEAD_BEEF);
      end
      tick();
    end

    // Simultaneous load transfer and return at count 5.
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 11'h000);
      tick();
    end
    chk("cnt5 before", 32'(bus.loads_out_o), 32'd5);
    drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 11'h000);
    #1;
    chk("cnt5 xfer ready", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("cnt5 after", 32'(bus.loads_out_o), 32'd5);

    // Lock on a lone requester 1 must survive requester 0 turning up.
    reset_dut();
    drive(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 11'h000);
    #1;
    chk("lock1 out_v", 32'(bus.out_v_o), 32'h1);
    chk("lock1 grant", 32'(bus.out_opq_o[10]), 32'h1);
    tick();
    drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 11'h000);
    #1;
    chk("lock1 held grant", 32'(bus.out_opq_o[10]), 32'h1);
    chk("lock1 held ready", 32'(bus.req_ready_o), 32'h0);
    tick();
    drive(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 11'h000);
    #1;
    chk("lock1 xfer ready", 32'(bus.req_ready_o), 32'h2);
    tick();

    // Store from requester 0 stalled three cycles while requester 1 waits.
    drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 11'h000);
    #1;
    chk("st0 addr", bus.out_addr_o, 32'h0000_0100);
    chk("st0 type", 32'(bus.out_type_o), 32'h1);
    chk("st0 data", bus.out_data_o, 32'hA5A5_0000);
    chk("st0 mask", 32'(bus.out_mask_o), 32'h3);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 11'h000);
      #1;
      chk($sformatf("st0 stall%0d addr", c), bus.out_addr_o, 32'h0000_0100);
      chk($sformatf("st0 stall%0d ready", c), 32'(bus.req_ready_o), 32'h0);
      tick();
    end
    drive(1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 11'h000);
    #1;
    chk("st0 xfer ready", 32'(bus.req_ready_o), 32'h1);
    tick();
    #1;
    chk("st0 next grant", 32'(bus.out_opq_o[10]), 32'h1);
    chk("st0 next ready", 32'(bus.req_ready_o), 32'h2);
    chk("st0 next addr", bus.out_addr_o, 32'h0000_0200);
    tick();
    chk("st0 loads", 32'(bus.loads_out_o), 32'd1);

    // Load cap: 16 outstanding, 17th stalls, store passes, one return frees a slot.
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 11'h000);
      tick();
    end
    chk("cap loads 16", 32'(bus.loads_out_o), 32'd16);
    drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 11'h000);
    #1;
    chk("cap load stalled out_v", 32'(bus.out_v_o), 32'h0);
    chk("cap load stalled ready", 32'(bus.req_ready_o), 32'h0);
    tick();
    chk("cap still 16", 32'(bus.loads_out_o), 32'd16);
    drive(1'b0, 2'b11, 2'b10, 1'b1, 1'b0, 11'h000);
    #1;
    chk("cap store out_v", 32'(bus.out_v_o), 32'h1);
    chk("cap store ready", 32'(bus.req_ready_o), 32'h2);
    tick();
    chk("cap after store", 32'(bus.loads_out_o), 32'd16);
    drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 11'h000);
    #1;
    chk("cap ret cycle out_v", 32'(bus.out_v_o), 32'h0);
    tick();
    chk("cap after ret", 32'(bus.loads_out_o), 32'd15);
    drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 11'h000);
    #1;
    chk("cap freed ready", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("cap back to 16", 32'(bus.loads_out_o), 32'd16);

    // Return with nothing outstanding, then reset in the middle of a lock.
    reset_dut();
    drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 11'h000);
    #1;
    chk("err ret_v", 32'(bus.ret_v_o), 32'h1);
    chk("err before", 32'(bus.err_o), 32'h0);
    tick();
    chk("err set", 32'(bus.err_o), 32'h1);
    chk("err no underflow", 32'(bus.loads_out_o), 32'd0);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 11'h000);
    tick();
    tick();
    chk("err sticky", 32'(bus.err_o), 32'h1);
    drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 11'h000);
    tick();
    drive(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 11'h000);
    #1;
    chk("midlock grant", 32'(bus.out_opq_o[10]), 32'h1);
    tick();
    drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 11'h400);
    #1;
    chk("rst out_v", 32'(bus.out_v_o), 32'h0);
    chk("rst req_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst ret_v", 32'(bus.ret_v_o), 32'h0);
    tick();
    chk("rst loads", 32'(bus.loads_out_o), 32'd0);
    chk("rst err", 32'(bus.err_o), 32'h0);
    drive(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 11'h000);
    #1;
    chk("post rst grant", 32'(bus.out_opq_o[10]), 32'h0);
    chk("post rst ready", 32'(bus.req_ready_o), 32'h1);
    tick();
    drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 11'h400);
    #1;
    chk("stale ret_v", 32'(bus.ret_v_o), 32'h2);
    tick();
    chk("stale ret err", 32'(bus.err_o), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
